// File: rtl/biquad_coeff_wb_slave.sv
// ---------------------------------------------------------------------------
// biquad_coeff_wb_slave
//
// Wishbone classic single-access responder for biquad coefficient loading.
// Coefficient writes are serialized onto an 18-bit valid/ready stream toward
// the biquad DSP chain, one beat per bus write. Per-channel saturating write
// counters are compared against the expected load sequence, and a CTRL write
// can pulse the coefficient-commit strobe and/or clear the counters.
//
// Ports:
//   wb_clk_i, wb_rst_i      clock, asynchronous active-high reset
//   wb_cyc_i, wb_stb_i,
//   wb_we_i, wb_adr_i[6:0],
//   wb_dat_i[31:0],
//   wb_sel_i[3:0]           Wishbone slave inputs (sel ignored, 32-bit only)
//   wb_dat_o[31:0]          read data, valid while wb_ack_o is high
//   wb_ack_o, wb_err_o      access complete / access failed (stream timeout)
//   coeff_dat_o[17:0]       coefficient value (wb_dat_i[17:0])
//   coeff_ch_o[2:0]         channel index (wb_adr_i[4:2])
//   coeff_valid_o           coefficient beat present
//   coeff_ready_i           downstream accepts the beat
//   coeff_update_o          one-cycle commit strobe
//
// Address map (byte address, low two bits ignored):
//   0x00        CTRL (write: bit0 update, bit16 clear) / STATUS (read)
//   0x04..0x1C  coefficient channels 1..7
//   0x20..0x7C  unmapped: acked, reads return 0, writes ignored
//
// Optional build macro BIQUAD_COEFF_READBACK_EN: each channel keeps an 18-bit
// shadow of its last accepted coefficient; channel reads then return
// {counter[7:0], 6'b0, shadow[17:0]} instead of the bare counter.
// ---------------------------------------------------------------------------
module biquad_coeff_wb_slave #(
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned CNT_BITS = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [6:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [17:0] coeff_dat_o,
  output logic [2:0]  coeff_ch_o,
  output logic        coeff_valid_o,
  input  logic        coeff_ready_i,
  output logic        coeff_update_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_UPDATE = 3'd2;
  localparam logic [2:0] S_ACK    = 3'd3;
  localparam logic [2:0] S_ERR    = 3'd4;

  localparam int unsigned   TW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  logic [2:0]       state_q, state_d;
  logic [17:0]      dat_q;
  logic [2:0]       ch_q;
  logic [TW-1:0]    tmr_q;
  logic             cyc_lost_q;
  logic             clr_q;
  logic             ovf_q;
  logic             tout_q;
  logic [31:0]      rdata_q, rdata_d;
  logic [7:0]       cnt_eq;
  logic [7:0]       cnt_ge;
  logic [7:0][31:0] ch_rd;

  logic [4:0] word;
  logic       is_ctrl, is_ch, req, accept, tout_hit, clr_now;
  logic       unused_ok;

  assign word     = wb_adr_i[6:2];
  assign is_ctrl  = (word == 5'd0);
  assign is_ch    = (word != 5'd0) && (word < 5'd8);
  assign req      = wb_cyc_i && wb_stb_i;
  assign accept   = (state_q == S_LOAD) && coeff_ready_i;
  // Timer counts LOAD cycles without ready; the last allowed cycle goes to ERR.
  assign tout_hit = (TIMEOUT != 0) && (state_q == S_LOAD) && !coeff_ready_i &&
                    (32'(tmr_q) == TIMEOUT - 1);
  // A CTRL clear takes effect on the ACK cycle, after any update pulse.
  assign clr_now  = (state_q == S_ACK) && clr_q;
  assign unused_ok = ^{wb_sel_i, wb_adr_i[1:0], wb_dat_i[31:18]};

  // Channel 0 is CTRL; keep its slots inert so indexing by ch/word is safe.
  assign cnt_eq[0] = 1'b1;
  assign cnt_ge[0] = 1'b0;
  assign ch_rd[0]  = '0;

  for (genvar gi = 1; gi < 8; gi++) begin : g_ch
    localparam int unsigned EXP = (gi == 1) ? 8 : (gi == 4) ? 3 : (gi >= 6) ? 1 : 4;
    logic [CNT_BITS-1:0] cnt_q;

    assign cnt_eq[gi] = (32'(cnt_q) == EXP);
    assign cnt_ge[gi] = (32'(cnt_q) >= EXP);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i)
        cnt_q <= '0;
      else if (clr_now)
        cnt_q <= '0;
      else if (accept && ch_q == 3'(gi) && cnt_q != CNT_MAX)
        cnt_q <= cnt_q + CNT_BITS'(1);
    end

`ifdef BIQUAD_COEFF_READBACK_EN
    logic [17:0] shadow_q;
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i)
        shadow_q <= '0;
      else if (clr_now)
        shadow_q <= '0;
      else if (accept && ch_q == 3'(gi))
        shadow_q <= dat_q;
    end
    assign ch_rd[gi] = {8'(cnt_q), 6'b0, shadow_q};
`else
    assign ch_rd[gi] = 32'(cnt_q);
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (wb_we_i && is_ch)        state_d = S_LOAD;
          else if (wb_we_i && is_ctrl) state_d = wb_dat_i[0] ? S_UPDATE : S_ACK;
          else                         state_d = S_ACK;
        end
      end
      S_LOAD: begin
        if (coeff_ready_i) state_d = S_ACK;
        else if (tout_hit) state_d = S_ERR;
      end
      S_UPDATE: state_d = S_ACK;
      default:  state_d = S_IDLE;
    endcase
  end

  // Read data is captured as the access is accepted and is zero otherwise.
  always_comb begin
    rdata_d = '0;
    if (state_q == S_IDLE && req && !wb_we_i) begin
      if (is_ctrl)    rdata_d = {29'd0, tout_q, ovf_q, &cnt_eq};
      else if (is_ch) rdata_d = ch_rd[word[2:0]];
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= S_IDLE;
      dat_q      <= '0;
      ch_q       <= '0;
      tmr_q      <= '0;
      cyc_lost_q <= 1'b0;
      clr_q      <= 1'b0;
      ovf_q      <= 1'b0;
      tout_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;

      if (state_q == S_IDLE && req && wb_we_i && is_ch) begin
        dat_q <= wb_dat_i[17:0];
        ch_q  <= word[2:0];
      end

      if (state_q != S_LOAD)  tmr_q <= '0;
      else if (!coeff_ready_i) tmr_q <= tmr_q + TW'(1);

      // The beat always completes; a master that left mid-beat gets no response.
      if (state_q == S_IDLE)                   cyc_lost_q <= 1'b0;
      else if (state_q == S_LOAD && !wb_cyc_i) cyc_lost_q <= 1'b1;

      if (state_q == S_IDLE && req && wb_we_i && is_ctrl) clr_q <= wb_dat_i[16];
      else if (state_q == S_ACK)                          clr_q <= 1'b0;

      if (clr_now)                      ovf_q <= 1'b0;
      else if (accept && cnt_ge[ch_q])  ovf_q <= 1'b1;

      if (tout_hit) tout_q <= 1'b1;
    end
  end

  assign wb_dat_o       = rdata_q;
  assign wb_ack_o       = (state_q == S_ACK) && !cyc_lost_q;
  assign wb_err_o       = (state_q == S_ERR) && !cyc_lost_q;
  assign coeff_dat_o    = dat_q;
  assign coeff_ch_o     = ch_q;
  assign coeff_valid_o  = (state_q == S_LOAD);
  assign coeff_update_o = (state_q == S_UPDATE);

endmodule

// File: doc/biquad_coeff_wb_slave.md
Name: biquad_coeff_wb_slave

Overview:
- Wishbone classic single-access responder that receives biquad coefficient writes and serializes them onto an 18-bit valid/ready coefficient load stream toward the biquad8 DSP chain.
- Tracks per-channel write counts and checks them against the expected load sequence.
- Issues the coefficient update strobe and, on timeout, a Wishbone error.
- Sits between the Wishbone interconnect and the biquad core, single clock domain.

Parameters:
- TIMEOUT, 255: max cycles waiting on coeff_ready_i before erroring; 0 disables the timeout.
- CNT_BITS, 4: width of each per-channel write counter (saturating).

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset; asynchronous, active-high.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  write enable.
- wb_adr_i  in  7  byte address.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte select (ignored; all accesses treated as 32-bit).
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  access complete.
- wb_err_o  out  1  access failed (timeout).
- coeff_dat_o  out  18  coefficient value, wb_dat_i[17:0].
- coeff_ch_o  out  3  channel index, wb_adr_i[4:2].
- coeff_valid_o  out  1  coefficient present.
- coeff_ready_i  in  1  downstream accepts coefficient.
- coeff_update_o  out  1  one-cycle pulse: commit loaded coefficients.

Behaviour:
- Reset (async, wb_rst_i=1): all outputs 0, counters 0, sticky status 0, FSM=IDLE.
- Address map, 7-bit byte address, low 2 bits ignored:
  - 0x00 CTRL/STATUS.
  - 0x04..0x1C coefficient channels 1..7.
  - Expected write counts per channel: 0x04=8, 0x08=4, 0x0C=4, 0x10=3, 0x14=4, 0x18=1, 0x1C=1.
  - 0x20..0x7C unmapped: ack next cycle, reads return 0, writes ignored.
- FSM states IDLE, LOAD, UPDATE, ACK, ERR:
  - IDLE: cyc&stb&we to a channel -> LOAD. cyc&stb&we to 0x00 -> UPDATE if wb_dat_i[0]=1, else ACK. Any read or unmapped access -> ACK.
  - LOAD: coeff_valid_o=1, with coeff_dat_o and coeff_ch_o registered from the bus.
    - On coeff_ready_i=1: drop valid, increment the channel counter, go to ACK.
    - Timeout counter runs from LOAD entry; TIMEOUT cycles without ready -> ERR (valid dropped, counter not incremented).
  - UPDATE: coeff_update_o=1 for exactly one cycle -> ACK.
  - ACK: wb_ack_o=1 for one cycle -> IDLE. ERR: wb_err_o=1 for one cycle, sticky timeout bit set -> IDLE.
- Minimum write latency: stb to ack = 3 cycles when ready is already high (IDLE, LOAD, ACK).
- The master drops stb the cycle after ack/err; the slave does not re-qualify stb in the ACK or ERR cycle.
- CTRL write:
  - bit0 = update.
  - bit16 = clear counters and the overflow flag.
  - 0x10001 pulses update first, then counters are cleared on the ACK cycle.
- STATUS read (wb_dat_o valid with ack):
  - bit0 = all 7 counters equal expected.
  - bit1 = sticky overflow (any write when counter >= expected).
  - bit2 = sticky timeout.
  - bits[31:3] = 0.
  - Timeout is cleared only by reset.
- Channel read returns the zero-extended counter value.
- Counters saturate at 2^CNT_BITS-1; overflowing writes are still forwarded downstream.
- cyc deasserted while in LOAD: keep valid until ready or timeout (stream transfers never abort mid-beat), then suppress the ack.
- Reset mid-LOAD: valid drops asynchronously and no update or ack is issued.

Optional Feature:
- Macro: BIQUAD_COEFF_READBACK_EN.
- Defined: each channel keeps an 18-bit shadow of its last accepted coefficient.
  - Channel read returns {counter in [31:24], 6'b0, shadow[17:0]}.
  - Shadows reset to 0 and are cleared by CTRL bit16.
- Undefined: no shadow registers; channel reads return the counter only.

Test Plan:
- Write 0x04 eight times (0x2137/0x35BF alternating), ready tied 1 -> eight valid beats with ch=1 and the matching data; each ack 3 cycles after stb; read 0x04 returns 8.
- Full sequence (8,4,4,3,4,1,1 writes), then read 0x00 -> 0x1. Write 0x10001 -> one coeff_update_o pulse; the following read of 0x00 returns 0x0 and all counters are 0.
- Write 0x18 with ready held low for 10 cycles -> valid held with data 0x3E766 and ch=6; ack on cycle 12 after stb; counter becomes 1.
- TIMEOUT=16, ready stuck at 0 -> wb_err_o pulses at 16 cycles, counter stays 0, status bit2=1, no coeff_update_o.
- Write 0x18 twice -> status bit1=1; write 0x10000 -> status bit1=0; write to 0x40 -> ack, no valid; read 0x40 -> 0.
- Assert wb_rst_i during LOAD -> coeff_valid_o=0 immediately, no ack; the next write completes normally.
